// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared types and helpers for the SPI serial-clock engine.
//   state_t        : engine state (idle, running a transfer, one-cycle done)
//   spi_mode_t     : SPI mode encoded as {cpol, cpha}
//   calc_divisor   : PCLK cycles per sclk half-period, (sppr+1) << (spr+1)
//   eff_nbits      : transfer length with 0 / oversize requests clamped
//   is_sample_edge : whether a given sclk edge carries the MISO sample strobe
//   is_shift_edge  : whether a given sclk edge carries the MOSI shift strobe
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_t;

    // Arguments are passed 32 bits wide so the helper is independent of the
    // field widths chosen by the instantiating module.
    function automatic logic [31:0] calc_divisor(input logic [31:0] pre,
                                                 input logic [31:0] ex);
        return (pre + 32'd1) << (ex + 32'd1);
    endfunction

    function automatic logic [31:0] eff_nbits(input logic [31:0] n,
                                              input logic [31:0] max_bits);
        return ((n == 32'd0) || (n > max_bits)) ? max_bits : n;
    endfunction

    // Edges are numbered from 1; odd edges are the leading edges of a bit.
    function automatic logic is_sample_edge(input logic pha, input logic odd);
        return pha ? !odd : odd;
    endfunction

    // With cpha=0 the final trailing edge has no next bit to shift out.
    function automatic logic is_shift_edge(input logic pha, input logic odd,
                                           input logic last);
        return pha ? odd : (!odd && !last);
    endfunction

endpackage

// File: rtl/spi_div_counter.sv
// ---------------------------------------------------------------------------
// spi_div_counter
// Free-running modulo-div counter used to time sclk half-periods.
//   PCLK, PRESETn : clock, asynchronous active-low reset
//   enable        : count while high, hold while low
//   clear         : synchronous clear to 0 (wins over enable)
//   div           : modulus, always >= 2
//   tick          : high in the cycle where count == div-1 (enabled)
//   pre_tick      : high in the cycle where count == div-2 (enabled)
// ---------------------------------------------------------------------------
module spi_div_counter #(
    parameter int DIV_W = 12
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic             pre_tick
);

    logic [DIV_W-1:0] count;

    assign tick     = enable && (count == (div - DIV_W'(1)));
    assign pre_tick = enable && (count == (div - DIV_W'(2)));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_sclk_engine.sv
// ---------------------------------------------------------------------------
// spi_sclk_engine
// SPI master serial-clock and bit-timing engine.
//   PCLK, PRESETn      : APB clock, asynchronous active-low reset
//   spe                : SPI enable
//   spiswai, wait_mode : stop-in-wait control; both high halts the engine
//   sppr, spr          : prescaler / exponent fields selecting the divisor
//   cpol, cpha         : SPI mode
//   nbits              : bits per transfer (0 or > MAX_BITS means MAX_BITS)
//   start              : single-cycle transfer request
//   busy, done         : transfer in progress / one-cycle completion pulse
//   aborted            : one-cycle pulse when a transfer is cut short
//   sclk               : serial clock
//   sample, shift      : MISO sample / MOSI shift strobes, aligned with sclk
//   sample_pre, shift_pre : the same strobes one PCLK earlier
//   divisor            : live (sppr+1)*2^(spr+1)
//   edge_cnt           : sclk edges issued in the current transfer
// BITCNT_W must hold 2*MAX_BITS, since edge_cnt counts up to 2*N.
// ---------------------------------------------------------------------------
module spi_sclk_engine
    import spi_pkg::*;
#(
    parameter int PRE_W    = 3,
    parameter int EXP_W    = 3,
    parameter int DIV_W    = 12,
    parameter int MAX_BITS = 16,
    parameter int BITCNT_W = 6
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                spe,
    input  logic                spiswai,
    input  logic                wait_mode,
    input  logic [PRE_W-1:0]    sppr,
    input  logic [EXP_W-1:0]    spr,
    input  logic                cpol,
    input  logic                cpha,
    input  logic [BITCNT_W-1:0] nbits,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                sclk,
    output logic                sample_pre,
    output logic                sample,
    output logic                shift_pre,
    output logic                shift,
    output logic [DIV_W-1:0]    divisor,
    output logic [BITCNT_W-1:0] edge_cnt
);

    state_t              state, state_nx;
    spi_mode_t           mode_l, mode_nx;
    logic [DIV_W-1:0]    div_l, div_nx;
    logic [BITCNT_W-1:0] n_l, n_nx;
    logic [BITCNT_W-1:0] edge_nx;
    logic                sclk_nx;
    logic                sample_nx, shift_nx, sample_pre_nx, shift_pre_nx;
    logic                aborted_nx;

    logic                run_ok;
    logic                accept;
    logic                cpol_l, cpha_l;
    logic [BITCNT_W-1:0] two_n;
    logic [BITCNT_W-1:0] e_next;
    logic                e_odd, e_last;
    logic                tick, pre_tick;

    assign divisor = DIV_W'(calc_divisor(32'(sppr), 32'(spr)));
    assign run_ok  = spe && !(spiswai && wait_mode);

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    assign cpol_l = (mode_l == MODE2) || (mode_l == MODE3);
    assign cpha_l = (mode_l == MODE1) || (mode_l == MODE3);
    assign two_n  = n_l << 1;

    // The edge about to be issued; it is the same edge whether we are at
    // the pre_tick or the tick cycle, so both strobes share one qualifier.
    assign e_next = edge_cnt + BITCNT_W'(1);
    assign e_odd  = e_next[0];
    assign e_last = (e_next == two_n);

    // The counter runs only in RUN with run_ok; it is held at zero in every
    // other state so the first RUN cycle always starts a fresh half-period.
    spi_div_counter #(
        .DIV_W (DIV_W)
    ) u_div_counter (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .enable   ((state == ST_RUN) && run_ok),
        .clear    (state != ST_RUN),
        .div      (div_l),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= ST_IDLE;
            mode_l     <= MODE0;
            div_l      <= '0;
            n_l        <= '0;
            edge_cnt   <= '0;
            sclk       <= 1'b0;
            sample     <= 1'b0;
            shift      <= 1'b0;
            sample_pre <= 1'b0;
            shift_pre  <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            state      <= state_nx;
            mode_l     <= mode_nx;
            div_l      <= div_nx;
            n_l        <= n_nx;
            edge_cnt   <= edge_nx;
            sclk       <= sclk_nx;
            sample     <= sample_nx;
            shift      <= shift_nx;
            sample_pre <= sample_pre_nx;
            shift_pre  <= shift_pre_nx;
            aborted    <= aborted_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        mode_nx       = mode_l;
        div_nx        = div_l;
        n_nx          = n_l;
        edge_nx       = edge_cnt;
        sclk_nx       = sclk;
        sample_nx     = 1'b0;
        shift_nx      = 1'b0;
        sample_pre_nx = 1'b0;
        shift_pre_nx  = 1'b0;
        aborted_nx    = 1'b0;
        accept        = 1'b0;

        case (state)
            ST_IDLE: begin
                sclk_nx = cpol;
                edge_nx = '0;
                accept  = start && run_ok;
            end

            ST_DONE: begin
                state_nx = ST_IDLE;
                sclk_nx  = cpol_l;
                edge_nx  = '0;
                accept   = start && run_ok;
            end

            ST_RUN: begin
                // Abort is checked first so it beats a coincident final edge.
                if (!run_ok) begin
                    state_nx   = ST_IDLE;
                    sclk_nx    = cpol;
                    edge_nx    = '0;
                    aborted_nx = 1'b1;
                end else if (edge_cnt == two_n) begin
                    state_nx = ST_DONE;
                end else begin
                    if (tick) begin
                        sclk_nx   = !sclk;
                        edge_nx   = e_next;
                        sample_nx = is_sample_edge(cpha_l, e_odd);
                        shift_nx  = is_shift_edge(cpha_l, e_odd, e_last);
                    end
                    if (pre_tick) begin
                        sample_pre_nx = is_sample_edge(cpha_l, e_odd);
                        shift_pre_nx  = is_shift_edge(cpha_l, e_odd, e_last);
                    end
                end
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // A start in IDLE or in the DONE cycle snapshots the live fields.
        if (accept) begin
            state_nx = ST_RUN;
            mode_nx  = spi_mode_t'({cpol, cpha});
            div_nx   = divisor;
            n_nx     = BITCNT_W'(eff_nbits(32'(nbits), 32'(MAX_BITS)));
            edge_nx  = '0;
            sclk_nx  = cpol;
        end
    end

endmodule
